mul_share_ctrl: RTL

// - Sequencer/arbiter sharing one multi-cycle shift-add multiplier datapath between two requesters.
// - Accepts operand pairs via valid/ready and issues the one-cycle load pulse to the datapath.
// - Waits out the fixed iteration count, captures the product and returns it via valid/ready with requester ID.
// - Sits between the issuing logic and the multiplier datapath (load/operands/product); one operation outstanding.

---
 rtl/mul_share_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mul_share_ctrl.sv
// ---------------------------------------------------------------------------
// mul_share_ctrl
// Sequencer/arbiter that shares one multi-cycle shift-add multiplier datapath
// between two requesters. One operation is outstanding at a time.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. reqN_ready is a combinational function of reqN_valid and the
// current state and pointer, so a requester holds valid and operands until it
// sees ready. rsp_valid stays high, with rsp_id/rsp_product stable, until the
// edge where rsp_ready is also high.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   req0_* / req1_*            requester operand channels (valid/ready, a, b)
//   rsp_valid/ready/id/product result channel with owning requester id
//   mul_load                   one-cycle load strobe to the datapath
//   mul_multiplier/multiplicand latched operands to the datapath
//   mul_product                datapath product, valid WIDTH clocks after load
//   busy                       high in any state but IDLE
//   state_dbg                  current FSM state (debug visibility)
//   perf_cnt0/perf_cnt1        saturating per-requester response counters,
//                              present only when MUL_SHARE_PERF_EN is defined
//
// Configuration macro: MUL_SHARE_PERF_EN
// ---------------------------------------------------------------------------
module mul_share_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [2*WIDTH-1:0] rsp_product,
    output logic               mul_load,
    output logic [WIDTH-1:0]   mul_multiplier,
    output logic [WIDTH-1:0]   mul_multiplicand,
    input  logic [2*WIDTH-1:0] mul_product,
    output logic               busy,
    output logic [1:0]         state_dbg
`ifdef MUL_SHARE_PERF_EN
    ,
    output logic [7:0]         perf_cnt0,
    output logic [7:0]         perf_cnt1
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               ptr_q;
    logic               id_q;
    logic [2*WIDTH-1:0] product_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   mcand_q;

    logic grant0, grant1, accept, rsp_fire;

    // Pointer only matters when both requesters are valid; it names the winner.
    assign grant0   = req0_valid & (~req1_valid | ~ptr_q);
    assign grant1   = req1_valid & (~req0_valid |  ptr_q);
    assign accept   = (state_q == S_IDLE) & (grant0 | grant1);
    assign rsp_fire = (state_q == S_DONE) & rsp_ready;

    assign req0_ready       = (state_q == S_IDLE) & grant0;
    assign req1_ready       = (state_q == S_IDLE) & grant1;
    assign rsp_valid        = (state_q == S_DONE);
    assign rsp_id           = id_q;
    assign rsp_product      = product_q;
    assign mul_load         = (state_q == S_LOAD);
    assign mul_multiplier   = mplier_q;
    assign mul_multiplicand = mcand_q;
    assign busy             = (state_q != S_IDLE);
    assign state_dbg        = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_LOAD;
            S_LOAD: state_d = S_RUN;
            S_RUN:  if (cnt_q == LAST_CNT) state_d = S_DONE;
            S_DONE: if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ptr_q     <= 1'b0;
            id_q      <= 1'b0;
            product_q <= '0;
            mplier_q  <= '0;
            mcand_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mplier_q <= grant1 ? req1_a : req0_a;
                mcand_q  <= grant1 ? req1_b : req0_b;
                id_q     <= grant1;
            end
            if (state_q == S_LOAD) begin
                cnt_q <= '0;
            end else if (state_q == S_RUN) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            // The last RUN edge is WIDTH clocks past the load edge, so the
            // datapath product is settled here.
            if ((state_q == S_RUN) && (cnt_q == LAST_CNT)) begin
                product_q <= mul_product;
            end
            // Round-robin: the requester just served loses the next tie.
            if (rsp_fire) begin
                ptr_q <= ~id_q;
            end
        end
    end

`ifdef MUL_SHARE_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_cnt0 <= 8'h00;
            perf_cnt1 <= 8'h00;
        end else if (rsp_fire) begin
            if (!id_q && (perf_cnt0 != 8'hFF)) perf_cnt0 <= perf_cnt0 + 8'h01;
            if ( id_q && (perf_cnt1 != 8'hFF)) perf_cnt1 <= perf_cnt1 + 8'h01;
        end
    end
`endif

endmodule
